mem_ws: RTL and testbench
=========================

MEM_WS -- requirements
Module: mem_ws

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: address width.
REQ-003 SHALL have parameter DEPTH, default 256: number of words, 1 to 2**ADDR_W.
REQ-004 SHALL have parameter WAIT, default 0: wait states per access, 0 to 15.
REQ-005 SHALL have parameter SEED1, default 32'h04108041: initial content of word 1 (RTC seed, Yr 1 Day 1 1:01:01).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ce, input, 1 bit: chip enable.
REQ-009 SHALL have port sel, input, 1 bit: select, active low; a request is ce=1 with sel=0.
REQ-010 SHALL have port pwrite, input, 1 bit: 1 means write, 0 means read.
REQ-011 SHALL have port addr, input, ADDR_W bits: word address.
REQ-012 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-013 SHALL have port strb, input, DATA_W/8 bits: byte write enables; strb[k] covers bits [8k+7:8k].
REQ-014 SHALL have port rd_data, output, DATA_W bits: read data, valid while ready=1.
REQ-015 SHALL have port ready, output, 1 bit: one-cycle pulse marking completion.
REQ-016 SHALL have port err, output, 1 bit: out-of-range flag, valid while ready=1.

Function
REQ-017 SHALL use three states: IDLE, WAIT, DONE.
REQ-018 SHALL accept requests only in IDLE and register addr, wr_data, strb and pwrite on the accept edge; inputs need not be held after that edge.
REQ-019 SHALL go IDLE->WAIT on accept when WAIT>0, loading the wait counter with WAIT-1; SHALL go IDLE->DONE when WAIT=0.
REQ-020 SHALL decrement the counter each cycle in WAIT and go to DONE on the edge where it equals 0.
REQ-021 SHALL drive ready=1 for exactly one cycle in DONE, then return to IDLE; latency is WAIT+1 cycles from the accept cycle.
REQ-022 SHALL ignore requests presented in WAIT or DONE, with no queuing; back-to-back accepts are therefore spaced WAIT+2 cycles apart.
REQ-023 SHALL commit writes on the edge entering DONE, updating only the bytes whose strb bit is 1; strb=0 leaves the word unchanged.
REQ-024 SHALL register the read word on the edge entering DONE; rd_data holds its value outside DONE.
REQ-025 SHALL treat addr >= DEPTH as out of range: the write is dropped, a read returns 0, and err behaves per REQ-031.
REQ-026 SHALL leave rd_data unchanged on a write.
REQ-027 SHALL initialise memory to word i = i+10, except word 1 = SEED1, truncated or zero-extended to DATA_W; reset does not alter memory contents.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, counter=0, ready=0, err=0, rd_data=0.
REQ-029 SHALL drop any write not yet committed when reset is asserted mid-access (in WAIT); no memory word changes.
REQ-030 SHALL accept a request in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with macro MEM_WS_ERR_EN defined, drive err=1 in DONE for an out-of-range access, and 0 otherwise; without the macro, err is tied to 0 and out-of-range handling otherwise follows REQ-025.

Verification
REQ-032 SHALL check read-after-reset: with WAIT=0, read addr 1 -> ready 1 cycle after accept, rd_data=0x04108041, err=0; read addr 5 -> 0x0000000F.
REQ-033 SHALL check wait states: with WAIT=3, read addr 2 -> ready exactly 4 cycles after accept, one cycle wide, rd_data=0x0000000C; a request held during the busy cycles is not accepted.
REQ-034 SHALL check byte strobes: write 0xAABBCCDD to addr 7 with strb=4'b0101, then read addr 7 -> 0x00BB00DD (initial 0x00000011 with bytes 0 and 2 replaced, giving 0x00BB00DD).
REQ-035 SHALL check out-of-range: with DEPTH=200, write addr 210, then read addr 210 -> rd_data=0 with err=1 when MEM_WS_ERR_EN is defined, err=0 otherwise; words 0-199 are unchanged.
REQ-036 SHALL check reset mid-access: with WAIT=5, write 0x12345678 to addr 3 and pulse rst_n low in wait cycle 2 -> ready never asserts, outputs are 0, and a later read of addr 3 returns 0x0000000D.
REQ-037 SHALL check back-to-back traffic: with WAIT=0, write 0x55 to addr 9, then read addr 9 accepted in the first IDLE cycle after ready -> rd_data=0x00000055.

Source files
------------

// File: rtl/mem_ws.sv
// mem_ws: single-port word memory with a fixed number of wait states,
// byte write strobes and an out-of-range check.
// Optional feature: define MEM_WS_ERR_EN to drive err=1 in DONE for an
// out-of-range access; without it err is tied to 0.
module mem_ws #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 8,
  parameter int          DEPTH  = 256,
  parameter int          WAIT   = 0,
  parameter logic [31:0] SEED1  = 32'h04108041
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              sel,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              err
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  // Power-on image: word i holds i+10, word 1 holds the RTC seed.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i == 1) ? DATA_W'(SEED1) : DATA_W'(i + 10);
    end
    return m;
  endfunction

  localparam mem_t INIT = init_mem();

  mem_t              mem = INIT;
  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [NB-1:0]     strb_q;
  logic              write_q;

  logic              accept;
  logic              enter_done;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [NB-1:0]     c_strb;
  logic              c_write;
  logic              in_range;
  logic [IW-1:0]     idx;

  // With zero wait states the access completes on the accept edge itself,
  // so the commit path takes the live inputs in IDLE and the latched copy otherwise.
  always_comb begin
    accept     = (state == ST_IDLE) && ce && !sel;
    enter_done = ((state == ST_IDLE) && accept && (WAIT == 0)) ||
                 ((state == ST_WAIT) && (cnt == 4'd0));
    c_addr     = (state == ST_IDLE) ? addr    : addr_q;
    c_data     = (state == ST_IDLE) ? wr_data : data_q;
    c_strb     = (state == ST_IDLE) ? strb    : strb_q;
    c_write    = (state == ST_IDLE) ? pwrite  : write_q;
    in_range   = {1'b0, c_addr} < (ADDR_W+1)'(DEPTH);
    idx        = c_addr[IW-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE accepts, WAIT counts down, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef MEM_WS_ERR_EN
  logic err_q;

  // Out-of-range flag captured with the access, shown only in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (enter_done) err_q <= !in_range;
  end

  // Outputs decoded from the state.
  always_comb begin
    ready = (state == ST_DONE);
    err   = (state == ST_DONE) && err_q;
  end
`else
  // Outputs decoded from the state; err unused in this build.
  always_comb begin
    ready = (state == ST_DONE);
    err   = 1'b0;
  end
`endif

  // Request capture, wait counter and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rd_data <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        data_q  <= wr_data;
        strb_q  <= strb;
        write_q <= pwrite;
        if (WAIT > 0) cnt <= 4'(WAIT - 1);
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !c_write) rd_data <= in_range ? mem[idx] : '0;
    end
  end

  // Byte-masked write commit; reset held at the edge drops the write.
  always_ff @(posedge clk) begin
    if (enter_done && c_write && in_range && rst_n) begin
      for (int k = 0; k < NB; k++) begin
        if (c_strb[k]) mem[idx][8*k +: 8] <= c_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_ws.sv
// tb_mem_ws: scoreboard bench for mem_ws. Three instances share the request
// bus and are selected by their own chip enable: WAIT=0/DEPTH=200,
// WAIT=3/DEPTH=256 and WAIT=5/DEPTH=256.
module tb_mem_ws;

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic        err;
  } exp_t;

`ifdef MEM_WS_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [2:0]  ce_v    = '0;
  logic        sel     = 1'b1;
  logic        pwrite  = 1'b0;
  logic [7:0]  addr    = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  strb    = '0;
  logic [31:0] rd_a [3];
  logic [2:0]  rdy;
  logic [2:0]  er;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] last_rd [3];

  mem_ws #(.WAIT(0), .DEPTH(200)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce_v[0]), .sel(sel), .pwrite(pwrite),
    .addr(addr), .wr_data(wr_data), .strb(strb),
    .rd_data(rd_a[0]), .ready(rdy[0]), .err(er[0]));

  mem_ws #(.WAIT(3), .DEPTH(256)) u3 (
    .clk(clk), .rst_n(rst_n), .ce(ce_v[1]), .sel(sel), .pwrite(pwrite),
    .addr(addr), .wr_data(wr_data), .strb(strb),
    .rd_data(rd_a[1]), .ready(rdy[1]), .err(er[1]));

  mem_ws #(.WAIT(5), .DEPTH(256)) u5 (
    .clk(clk), .rst_n(rst_n), .ce(ce_v[2]), .sel(sel), .pwrite(pwrite),
    .addr(addr), .wr_data(wr_data), .strb(strb),
    .rd_data(rd_a[2]), .ready(rdy[2]), .err(er[2]));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request on instance id, queue its expected response, then
  // measure latency and the width of the ready pulse.
  task automatic applyStimulus(input int id, input logic wr, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] exp_rd, input logic exp_err,
                               input int exp_lat, input bit hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    ce_v     = '0;
    ce_v[id] = 1'b1;
    sel      = 1'b0;
    pwrite   = wr;
    addr     = a;
    wr_data  = d;
    strb     = s;
    e.id  = id;
    e.rd  = wr ? last_rd[id] : exp_rd;
    e.err = exp_err;
    sb.push_back(e);
    if (!wr) last_rd[id] = exp_rd;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (!hold && lat == 1) begin
        ce_v = '0;
        sel  = 1'b1;
      end
    end while (!rdy[id] && lat < 30);
    ce_v   = '0;
    sel    = 1'b1;
    pwrite = 1'b0;
    checkOutput($sformatf("latency_u%0d", id), 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    checkOutput($sformatf("ready_width_u%0d", id), 32'(rdy[id]), 32'd0);
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rdy[i]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: u%0d ready=1, expected no response", i);
        end else begin
          e = sb.pop_front();
          checkOutput("response_instance", 32'(i), 32'(e.id));
          checkOutput($sformatf("rd_data_u%0d", i), rd_a[i], e.rd);
          checkOutput($sformatf("err_u%0d", i), 32'(er[i]), 32'(e.err));
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_ready_u%0d", i), 32'(rdy[i]), 32'd0);
      checkOutput($sformatf("reset_rd_data_u%0d", i), rd_a[i], 32'd0);
      checkOutput($sformatf("reset_err_u%0d", i), 32'(er[i]), 32'd0);
    end
    rst_n = 1'b1;

    // WAIT=0: seeded word and plain word, accepted right after reset.
    applyStimulus(0, 1'b0, 8'd1, 32'h0, 4'h0, 32'h04108041, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd5, 32'h0, 4'h0, 32'h0000000F, 1'b0, 1, 1'b0);
    // Byte strobes and an all-zero strobe.
    applyStimulus(0, 1'b1, 8'd7, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd7, 32'h0, 4'h0, 32'h00BB00DD, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b1, 8'd8, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd8, 32'h0, 4'h0, 32'h00000012, 1'b0, 1, 1'b0);
    // Out of range on DEPTH=200, then neighbouring words untouched.
    applyStimulus(0, 1'b1, 8'd210, 32'hDEADBEEF, 4'hF, 32'h0, ERR_ON, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd210, 32'h0, 4'h0, 32'h00000000, ERR_ON, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd199, 32'h0, 4'h0, 32'h000000D1, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd10, 32'h0, 4'h0, 32'h00000014, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd0, 32'h0, 4'h0, 32'h0000000A, 1'b0, 1, 1'b0);
    // Back-to-back write then read.
    applyStimulus(0, 1'b1, 8'd9, 32'h00000055, 4'hF, 32'h0, 1'b0, 1, 1'b0);
    applyStimulus(0, 1'b0, 8'd9, 32'h0, 4'h0, 32'h00000055, 1'b0, 1, 1'b0);

    // WAIT=3: request held through the busy cycles is taken only once.
    applyStimulus(1, 1'b0, 8'd2, 32'h0, 4'h0, 32'h0000000C, 1'b0, 4, 1'b1);
    applyStimulus(1, 1'b0, 8'd4, 32'h0, 4'h0, 32'h0000000E, 1'b0, 4, 1'b0);

    // WAIT=5: reset in the second wait cycle drops the pending write.
    applyStimulus(2, 1'b0, 8'd6, 32'h0, 4'h0, 32'h00000010, 1'b0, 6, 1'b0);
    @(negedge clk);
    ce_v[2] = 1'b1;
    sel     = 1'b0;
    pwrite  = 1'b1;
    addr    = 8'd3;
    wr_data = 32'h12345678;
    strb    = 4'hF;
    @(posedge clk);
    #1;
    ce_v   = '0;
    sel    = 1'b1;
    pwrite = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ready_u2", 32'(rdy[2]), 32'd0);
    checkOutput("midreset_rd_data_u2", rd_a[2], 32'd0);
    checkOutput("midreset_err_u2", 32'(er[2]), 32'd0);
    checkOutput("midreset_rd_data_u0", rd_a[0], 32'd0);
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(2, 1'b0, 8'd3, 32'h0, 4'h0, 32'h0000000D, 1'b0, 6, 1'b0);
    applyStimulus(0, 1'b0, 8'd7, 32'h0, 4'h0, 32'h00BB00DD, 1'b0, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
